mtx_mac: RTL and testbench

MTX_MAC -- requirements
Module: mtx_mac

---
 rtl/mtx_mac_if.sv | 26 ++
 rtl/mtx_mac.sv | 88 ++++++++
 tb/tb_mtx_mac.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtx_mac_if.sv
// Bus bundle between the matrix sequencer/register file and the dot-product MAC.
// An op is offered every cycle; it is taken only when sysser & romold & ~mtx_wait and the
// sysins class field is 3'b010. There is no back-pressure. The result is pushed with a one-cycle result_wr.
interface mtx_mac_if;
  logic        sysser;
  logic [15:0] sysins;
  logic        romold;
  logic        mtx_wait;
  logic        multsel;
  logic        mem_hi;
  logic [31:0] reg_din;
  logic [31:0] mem_din;
  logic [31:0] result;
  logic        result_wr;
  logic        mac_busy;

  modport master (
    output sysser, sysins, romold, mtx_wait, multsel, mem_hi, reg_din, mem_din,
    input  result, result_wr, mac_busy
  );

  modport slave (
    input  sysser, sysins, romold, mtx_wait, multsel, mem_hi, reg_din, mem_din,
    output result, result_wr, mac_busy
  );
endinterface

// File: rtl/mtx_mac.sv
// Two-stage multiply-accumulate for matrix dot products: stage P registers the 16x16 product,
// and stage A folds the product into the accumulator or publishes the accumulator as the result.
module mtx_mac #(
  parameter bit SIGNED_OPS = 1'b1
) (
  input logic      clk,
  input logic      reset_n,
  mtx_mac_if.slave bus
);

  localparam logic [2:0] OP_IMULT  = 3'b010;
  localparam logic [2:0] OP_IMAC   = 3'b100;
  localparam logic [2:0] OP_RESMAC = 3'b011;

  logic        w_fire;
  logic        w_legal;
  logic        w_cap;
  logic [2:0]  w_op;
  logic [15:0] w_a_half;
  logic [15:0] w_b_half;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_prod;
  logic        w_unused;

  logic        r_pv;
  logic [2:0]  r_pop;
  logic [31:0] r_prod;
  logic [31:0] r_acc;
  logic [31:0] r_result;
  logic        r_result_wr;

  assign w_op    = bus.sysins[12:10];
  assign w_fire  = bus.sysser & bus.romold & ~bus.mtx_wait & (bus.sysins[15:13] == 3'b010);
  assign w_legal = (w_op == OP_IMULT) | (w_op == OP_IMAC) | (w_op == OP_RESMAC);
  // Undefined op codes never enter the pipe, so they cannot disturb acc or result.
  assign w_cap   = w_fire & w_legal;

  assign w_a_half = bus.multsel ? bus.reg_din[31:16] : bus.reg_din[15:0];
  assign w_b_half = bus.mem_hi  ? bus.mem_din[31:16] : bus.mem_din[15:0];
  assign w_a      = SIGNED_OPS ? {{16{w_a_half[15]}}, w_a_half} : {16'h0000, w_a_half};
  assign w_b      = SIGNED_OPS ? {{16{w_b_half[15]}}, w_b_half} : {16'h0000, w_b_half};
  // The low 32 bits of the extended operands' product equal the exact 16x16 product in either mode.
  assign w_prod   = w_a * w_b;

  assign w_unused = &{1'b0, bus.sysins[9:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pv   <= 1'b0;
      r_pop  <= 3'b000;
      r_prod <= 32'h0;
    end else if (w_cap) begin
      r_pv   <= 1'b1;
      r_pop  <= w_op;
      r_prod <= w_prod;
    end else begin
      r_pv   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= 32'h0;
      r_result    <= 32'h0;
      r_result_wr <= 1'b0;
    end else begin
      r_result_wr <= 1'b0;
      if (r_pv) begin
        case (r_pop)
          OP_IMULT:  r_acc <= r_prod;
          OP_IMAC:   r_acc <= r_acc + r_prod;
          OP_RESMAC: begin
            r_result    <= r_acc;
            r_result_wr <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.result_wr = r_result_wr;
  // Stage A's update is pending exactly while stage P holds a valid op.
  assign bus.mac_busy  = r_pv;

endmodule

// File: tb/tb_mtx_mac.sv
// Bench for mtx_mac: a signed and an unsigned instance share one stimulus stream and are
// checked against an in-order dot-product model plus directed scenario expectations.
module tb_mtx_mac;

  localparam logic [2:0] C_IMULT  = 3'b010;
  localparam logic [2:0] C_IMAC   = 3'b100;
  localparam logic [2:0] C_RESMAC = 3'b011;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   edge_cnt;

  mtx_mac_if bus_s ();
  mtx_mac_if bus_u ();

  mtx_mac #(.SIGNED_OPS(1'b1)) u_dut_s (.clk(clk), .reset_n(reset_n), .bus(bus_s.slave));
  mtx_mac #(.SIGNED_OPS(1'b0)) u_dut_u (.clk(clk), .reset_n(reset_n), .bus(bus_u.slave));

  // Model state: the accumulators as the op sequence defines them, plus the scheduled result writes.
  logic [31:0] acc_s;
  logic [31:0] acc_u;
  logic [31:0] res_s;
  logic [31:0] res_u;
  logic [31:0] exp_q_s[$];
  logic [31:0] exp_q_u[$];
  int          due_q[$];
  int          cap_edge;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_prod(input bit sgn, input logic [31:0] rd, input bit ms,
                                            input logic [31:0] md, input bit mh);
    logic [15:0] ha;
    logic [15:0] hb;
    longint      a;
    longint      b;
    longint      p;
    ha = ms ? rd[31:16] : rd[15:0];
    hb = mh ? md[31:16] : md[15:0];
    a  = sgn ? longint'($signed(ha)) : longint'(ha);
    b  = sgn ? longint'($signed(hb)) : longint'(hb);
    p  = a * b;
    return p[31:0];
  endfunction

  function automatic logic [15:0] mk_ins(input logic [2:0] top, input logic [2:0] code);
    logic [9:0] low;
    low = 10'($urandom);
    return {top, code, low};
  endfunction

  task automatic model_reset();
    acc_s = 32'h0; acc_u = 32'h0; res_s = 32'h0; res_u = 32'h0;
    exp_q_s.delete(); exp_q_u.delete(); due_q.delete();
    cap_edge = -1;
  endtask

  task automatic set_inputs(input bit ser, input logic [15:0] ins, input bit rom, input bit wt,
                            input logic [31:0] rd, input bit ms, input logic [31:0] md, input bit mh);
    bus_s.sysser = ser; bus_s.sysins = ins; bus_s.romold = rom; bus_s.mtx_wait = wt;
    bus_s.reg_din = rd; bus_s.multsel = ms; bus_s.mem_din = md; bus_s.mem_hi = mh;
    bus_u.sysser = ser; bus_u.sysins = ins; bus_u.romold = rom; bus_u.mtx_wait = wt;
    bus_u.reg_din = rd; bus_u.multsel = ms; bus_u.mem_din = md; bus_u.mem_hi = mh;
  endtask

  // Driver with scoreboard: checks the outputs left by the edge just passed, then presents
  // the next cycle's inputs and advances the model if those inputs constitute a fire.
  task automatic drive(input bit ser, input logic [15:0] ins, input bit rom, input bit wt,
                       input logic [31:0] rd, input bit ms, input logic [31:0] md, input bit mh);
    bit          exp_wr;
    logic [31:0] ps;
    logic [31:0] pu;
    @(negedge clk);
    exp_wr = (due_q.size() > 0) && (due_q[0] == edge_cnt);
    if (exp_wr) begin
      res_s = exp_q_s.pop_front();
      res_u = exp_q_u.pop_front();
      void'(due_q.pop_front());
    end
    checks += 6;
    if (bus_s.result_wr !== exp_wr) begin
      errors++; $display("FAIL sb_wr_s: edge %0d got %b expected %b", edge_cnt, bus_s.result_wr, exp_wr);
    end
    if (bus_u.result_wr !== exp_wr) begin
      errors++; $display("FAIL sb_wr_u: edge %0d got %b expected %b", edge_cnt, bus_u.result_wr, exp_wr);
    end
    if (bus_s.result !== res_s) begin
      errors++; $display("FAIL sb_result_s: edge %0d got %h expected %h", edge_cnt, bus_s.result, res_s);
    end
    if (bus_u.result !== res_u) begin
      errors++; $display("FAIL sb_result_u: edge %0d got %h expected %h", edge_cnt, bus_u.result, res_u);
    end
    if (bus_s.mac_busy !== (cap_edge == edge_cnt)) begin
      errors++; $display("FAIL sb_busy_s: edge %0d got %b expected %b", edge_cnt, bus_s.mac_busy, cap_edge == edge_cnt);
    end
    if (bus_u.mac_busy !== (cap_edge == edge_cnt)) begin
      errors++; $display("FAIL sb_busy_u: edge %0d got %b expected %b", edge_cnt, bus_u.mac_busy, cap_edge == edge_cnt);
    end
    set_inputs(ser, ins, rom, wt, rd, ms, md, mh);
    if (reset_n && ser && rom && !wt && ins[15:13] == 3'b010) begin
      ps = ref_prod(1'b1, rd, ms, md, mh);
      pu = ref_prod(1'b0, rd, ms, md, mh);
      case (ins[12:10])
        C_IMULT: begin acc_s = ps; acc_u = pu; cap_edge = edge_cnt + 1; end
        C_IMAC:  begin acc_s = acc_s + ps; acc_u = acc_u + pu; cap_edge = edge_cnt + 1; end
        C_RESMAC: begin
          exp_q_s.push_back(acc_s);
          exp_q_u.push_back(acc_u);
          due_q.push_back(edge_cnt + 2);
          cap_edge = edge_cnt + 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic op(input logic [2:0] code, input logic [31:0] rd, input bit ms,
                    input logic [31:0] md, input bit mh);
    drive(1'b1, mk_ins(3'b010, code), 1'b1, 1'b0, rd, ms, md, mh);
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, $urandom, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_inputs(1'b0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus_s.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus_s.result); end
    if (bus_s.result_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", bus_s.result_wr); end
    if (bus_s.mac_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_s.mac_busy); end
    if (bus_u.result !== 32'h0) begin errors++; $display("FAIL reset_result_u: got %h expected 0", bus_u.result); end
    reset_n = 1'b1;
    repeat (3) idle();
  endtask

  task automatic test_dot_product();
    op(C_IMULT, 32'h0000_0003, 1'b0, 32'h0000_FFFC, 1'b0);
    op(C_IMAC,  32'h0000_0005, 1'b0, 32'h0000_0006, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle();
    checks++;
    if (bus_s.result_wr !== 1'b0) begin errors++; $display("FAIL dot_wr_early: got %b expected 0", bus_s.result_wr); end
    idle();
    checks += 2;
    if (bus_s.result_wr !== 1'b1) begin errors++; $display("FAIL dot_wr: got %b expected 1", bus_s.result_wr); end
    if (bus_s.result !== 32'h0000_0012) begin errors++; $display("FAIL dot_result: got %h expected 00000012", bus_s.result); end
    idle();
    checks += 2;
    if (bus_s.result_wr !== 1'b0) begin errors++; $display("FAIL dot_wr_once: got %b expected 0", bus_s.result_wr); end
    if (bus_s.result !== 32'h0000_0012) begin errors++; $display("FAIL dot_hold: got %h expected 00000012", bus_s.result); end
  endtask

  task automatic test_half_select();
    op(C_IMULT, 32'h0002_7FFF, 1'b1, 32'hFFFF_0003, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    checks++;
    if (bus_s.result !== 32'h0000_0006) begin errors++; $display("FAIL half_hi_lo: got %h expected 00000006", bus_s.result); end
    op(C_IMULT, 32'h0002_7FFF, 1'b0, 32'hFFFF_0003, 1'b1);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    checks += 2;
    if (bus_s.result !== 32'hFFFF_8001) begin errors++; $display("FAIL half_lo_hi: got %h expected ffff8001", bus_s.result); end
    if (bus_u.result !== 32'h7FFE_8001) begin errors++; $display("FAIL half_lo_hi_u: got %h expected 7ffe8001", bus_u.result); end
  endtask

  task automatic test_stall();
    op(C_IMULT, 32'h0000_0002, 1'b0, 32'h0000_0002, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk_ins(3'b010, C_IMAC), 1'b1, 1'b1, $urandom, 1'b0, $urandom, 1'b0);
      checks++;
      if (bus_s.mac_busy !== (i == 0)) begin
        errors++; $display("FAIL stall_busy%0d: got %b expected %b", i, bus_s.mac_busy, i == 0);
      end
    end
    op(C_IMAC, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    checks++;
    if (bus_s.result !== 32'h0000_0005) begin errors++; $display("FAIL stall_result: got %h expected 00000005", bus_s.result); end
  endtask

  task automatic test_wrap();
    op(C_IMULT, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF, 1'b0);
    op(C_IMAC,  32'h0000_FFFF, 1'b0, 32'h0000_FFFF, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    checks += 2;
    if (bus_u.result !== 32'hFFFC_0002) begin errors++; $display("FAIL wrap_u: got %h expected fffc0002", bus_u.result); end
    if (bus_s.result !== 32'h0000_0002) begin errors++; $display("FAIL wrap_s: got %h expected 00000002", bus_s.result); end
  endtask

  task automatic test_reset_mid();
    op(C_IMULT, 32'h0000_0007, 1'b0, 32'h0000_0001, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    set_inputs(1'b0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_reset();
    #1;
    checks += 4;
    if (bus_s.result !== 32'h0) begin errors++; $display("FAIL rmid_result: got %h expected 0", bus_s.result); end
    if (bus_u.result !== 32'h0) begin errors++; $display("FAIL rmid_result_u: got %h expected 0", bus_u.result); end
    if (bus_s.mac_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus_s.mac_busy); end
    if (bus_s.result_wr !== 1'b0) begin errors++; $display("FAIL rmid_wr: got %b expected 0", bus_s.result_wr); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++;
      if (bus_s.result_wr !== 1'b0) begin errors++; $display("FAIL rmid_late_wr%0d: got %b expected 0", i, bus_s.result_wr); end
    end
    op(C_IMAC, 32'h0000_0001, 1'b0, 32'h0000_0003, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    checks++;
    if (bus_s.result !== 32'h0000_0003) begin errors++; $display("FAIL rmid_acc_clear: got %h expected 00000003", bus_s.result); end
  endtask

  task automatic test_illegal();
    op(C_IMULT, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0);
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b1, mk_ins(3'b011, C_IMULT), 1'b1, 1'b0, $urandom, 1'b0, $urandom, 1'b0);
        1: drive(1'b1, mk_ins(3'b010, 3'b110), 1'b1, 1'b0, $urandom, 1'b0, $urandom, 1'b0);
        2: drive(1'b0, mk_ins(3'b010, C_IMULT), 1'b1, 1'b0, $urandom, 1'b0, $urandom, 1'b0);
        default: drive(1'b1, mk_ins(3'b010, C_RESMAC), 1'b0, 1'b0, $urandom, 1'b0, $urandom, 1'b0);
      endcase
      idle();
      checks += 3;
      if (bus_s.mac_busy !== 1'b0) begin errors++; $display("FAIL illegal_busy%0d: got %b expected 0", i, bus_s.mac_busy); end
      if (bus_s.result_wr !== 1'b0) begin errors++; $display("FAIL illegal_wr%0d: got %b expected 0", i, bus_s.result_wr); end
      if (bus_s.result !== 32'h0000_0010) begin errors++; $display("FAIL illegal_result%0d: got %h expected 00000010", i, bus_s.result); end
    end
    op(C_RESMAC, $urandom, 1'b0, $urandom, 1'b0);
    idle(); idle();
    checks++;
    if (bus_s.result !== 32'h0000_0010) begin errors++; $display("FAIL illegal_acc: got %h expected 00000010", bus_s.result); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes[6];
    logic [2:0] top;
    codes = '{C_IMULT, C_IMAC, C_RESMAC, C_IMAC, 3'b000, 3'b110};
    for (int i = 0; i < 200; i++) begin
      top = ($urandom_range(0, 7) == 0) ? 3'b011 : 3'b010;
      drive($urandom_range(0, 9) != 0, mk_ins(top, codes[$urandom_range(0, 5)]),
            $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            $urandom, 1'($urandom), $urandom, 1'($urandom));
    end
    repeat (3) idle();
    checks++;
    if (due_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending expected 0", due_q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_dot_product();
    test_half_select();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
